instr_fetch: RTL
================

# instr_fetch

- Instruction-fetch stage of the MIPS pipeline; wraps around the `pc` register.
  - Consumes the current PC.
  - Computes the next PC and drives the PC's address and enable inputs.
  - Reads instruction memory and holds the fetched word in the IF/ID pipeline register.
- Also owns program loading: a byte stream from the debug unit is assembled into words and written to instruction memory before execution starts.

## Interface
Parameters:
- NB_DATA, 32, data/address width
- NB_ADDR, 8, word-address bits; memory depth = 2^NB_ADDR words
- NB_BYTE, 8, loader byte width

Ports:
- i_clock  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global step enable from debug unit
- i_pc  in  NB_DATA  current PC (from `pc` o_addr)
- o_next_pc  out  NB_DATA  next PC (to `pc` i_addr), combinational
- o_pc_enable  out  1  to `pc` i_enable, combinational
- i_stall  in  1  hazard-unit stall
- i_flush  in  1  squash IF/ID contents
- i_branch_taken  in  1  branch resolved taken
- i_branch_addr  in  NB_DATA  branch target
- i_jump  in  1  jump
- i_jump_addr  in  NB_DATA  jump target
- i_load_start  in  1  begin program load
- i_wr_en  in  1  loader byte valid
- i_wr_byte  in  NB_BYTE  loader byte
- o_instr  out  NB_DATA  IF/ID instruction
- o_pc_plus4  out  NB_DATA  IF/ID PC+4
- o_valid  out  1  IF/ID holds a real fetch
- o_loading  out  1  state == LOAD
- o_halt  out  1  state == HALTED

## Operation
- FSM states: IDLE, LOAD, RUN, HALTED. Reset state is IDLE.
  - IDLE: i_load_start → LOAD.
  - LOAD: bytes are written to memory (see loader). Leaves for RUN when the HALT word (32'hFFFFFFFF) has been written, or when the word at index 2^NB_ADDR−1 has been written.
  - RUN: fetch active. Latching HALT into IF/ID moves to HALTED on the same edge.
  - HALTED: i_load_start → LOAD; no other exit.
- Loader:
  - Entering LOAD clears the byte counter and word pointer to 0.
  - Each i_wr_en cycle shifts one byte in, most-significant byte first.
  - On the 4th byte, the assembled word is written to mem[ptr] and ptr increments.
  - i_wr_en is ignored outside LOAD.
  - Memory contents are not cleared by reset.
- Fetch read is combinational: mem[i_pc[NB_ADDR+1:2]]. Any nonzero i_pc[NB_DATA-1:NB_ADDR+2] returns NOP (0).
- Next PC, in priority order:
  1. i_branch_taken → i_branch_addr
  2. i_jump → i_jump_addr
  3. otherwise i_pc + 4, modulo 2^NB_DATA (0xFFFFFFFC → 0x00000000)
- o_pc_enable = (state == RUN) & i_enable & ~i_stall.
- IF/ID update applies only in RUN with i_enable = 1, in priority order:
  1. i_flush: o_instr = 0, o_valid = 0, o_pc_plus4 = 0.
  2. i_stall: hold.
  3. Otherwise: latch the fetched word, i_pc + 4, and o_valid = 1.
- In all other states/conditions IF/ID holds.

## Timing
- Reset (asynchronous, immediate) values:
  - state IDLE
  - o_instr 0, o_pc_plus4 0, o_valid 0, o_halt 0, o_loading 0, o_pc_enable 0
  - byte counter 0, ptr 0
- Fetch latency: one cycle from i_pc to o_instr.
- Memory write occurs on the edge that samples the 4th byte. The LOAD→RUN transition happens on that same edge.
- HALT latch edge: `pc` also advances on that edge (o_pc_enable was 1), so PC = halt address + 4. From the next cycle o_pc_enable = 0 and PC is frozen.
- Flush and HALT fetched on the same edge: flush wins; no transition to HALTED.
- Flush and stall together: flush wins.
- i_load_start while in RUN: ignored.
- Reset mid-LOAD: any partially assembled word is discarded; words already written remain in memory.

## Configuration
- Macro: IF_MISALIGN_CHECK_EN.
- Defined:
  - If i_pc[1:0] != 0, the fetched word is forced to NOP (0).
  - o_valid latches 0 for that fetch.
  - The state moves to HALTED on the latch edge.
- Undefined: i_pc[1:0] are ignored; the word at i_pc[NB_ADDR+1:2] is fetched normally.

## Test plan
- Load: load_start, then bytes 20 01 00 05 and FF FF FF FF → mem[0] = 0x20010005, mem[1] = 0xFFFFFFFF, state RUN after the 8th byte, o_loading falls.
- Run to halt: PC starts at 0 → edge 1: o_instr = 0x20010005, o_pc_plus4 = 4. Edge 2: o_instr = 0xFFFFFFFF, o_halt = 1. Afterwards o_pc_enable = 0 and PC stays at 8.
- Stall/flush: stall held for 2 cycles → o_instr and o_pc_enable frozen. Flush together with stall → o_instr = 0, o_valid = 0.
- Next-PC priority:
  - branch_taken = 1 (addr 0x40) with jump = 1 (addr 0x80) → o_next_pc = 0x40.
  - Neither asserted, i_pc = 0xFFFFFFFC → o_next_pc = 0.
- Out-of-range fetch: i_pc = 0x00001000 with NB_ADDR = 8 → o_instr = 0 after one edge.
- Async reset mid-LOAD after 2 bytes → outputs 0 immediately, state IDLE. A new load_start restarts at ptr 0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch -- MIPS instruction-fetch stage wrapped around the external `pc`
// register, plus the program loader that fills instruction memory.
//
// Optional feature (macro IF_MISALIGN_CHECK_EN): a fetch from a PC whose two
// low bits are nonzero returns NOP, latches o_valid = 0 and halts the stage.
// Without the macro the two low PC bits are ignored.
//
// Ports:
//   i_clock, i_reset           clock, asynchronous active-high reset
//   i_enable                   global step enable from the debug unit
//   i_pc / o_next_pc           current PC in, next PC out (combinational)
//   o_pc_enable                write enable for the `pc` register
//   i_stall, i_flush           hazard-unit hold / squash of IF/ID
//   i_branch_taken/_addr       resolved branch redirect (highest priority)
//   i_jump/_addr               jump redirect
//   i_load_start, i_wr_en,     program loader: start, byte valid, byte
//   i_wr_byte                    (most-significant byte of each word first)
//   o_instr, o_pc_plus4,       IF/ID pipeline register
//   o_valid
//   o_loading, o_halt          FSM status (LOAD / HALTED)
module instr_fetch #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_DATA-1:0] i_pc,
  output logic [NB_DATA-1:0] o_next_pc,
  output logic               o_pc_enable,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_branch_taken,
  input  logic [NB_DATA-1:0] i_branch_addr,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_jump_addr,
  input  logic               i_load_start,
  input  logic               i_wr_en,
  input  logic [NB_BYTE-1:0] i_wr_byte,
  output logic [NB_DATA-1:0] o_instr,
  output logic [NB_DATA-1:0] o_pc_plus4,
  output logic               o_valid,
  output logic               o_loading,
  output logic               o_halt
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_CNT         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int DEPTH          = 1 << NB_ADDR;
  localparam logic [NB_DATA-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALTED} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- loader
  logic [NB_CNT-1:0]          byte_cnt;
  logic [NB_ADDR-1:0]         wr_ptr;
  logic [NB_DATA-NB_BYTE-1:0] shift_q;   // bytes already received for this word
  logic [NB_DATA-1:0]         asm_word;
  logic                       byte_wr, word_wr, last_byte, load_entry;

  assign asm_word   = {shift_q, i_wr_byte};
  assign byte_wr    = (state == LOAD) && i_wr_en;
  assign last_byte  = (byte_cnt == NB_CNT'(BYTES_PER_WORD - 1));
  assign word_wr    = byte_wr && last_byte;
  assign load_entry = (state != LOAD) && (state_nxt == LOAD);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      byte_cnt <= '0;
      wr_ptr   <= '0;
      shift_q  <= '0;
    end else if (load_entry) begin
      byte_cnt <= '0;
      wr_ptr   <= '0;
      shift_q  <= '0;
    end else if (byte_wr) begin
      shift_q <= asm_word[NB_DATA-NB_BYTE-1:0];
      if (last_byte) begin
        byte_cnt <= '0;
        wr_ptr   <= wr_ptr + 1'b1;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  // Instruction memory survives reset, so it lives in its own clock-only block.
  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (word_wr) mem[wr_ptr] <= asm_word;
  end

  // ----------------------------------------------------------------- fetch
  logic               pc_in_range, misaligned;
  logic [NB_DATA-1:0] fetch_word;

  assign pc_in_range = (i_pc[NB_DATA-1:NB_ADDR+2] == '0);

`ifdef IF_MISALIGN_CHECK_EN
  assign misaligned = (i_pc[1:0] != 2'b00);
`else
  logic unused_pc_lsb;
  assign misaligned    = 1'b0;
  assign unused_pc_lsb = ^i_pc[1:0];
`endif

  assign fetch_word = (pc_in_range && !misaligned) ? mem[i_pc[NB_ADDR+1:2]] : '0;

  // Branch beats jump; sequential increment wraps naturally at NB_DATA bits.
  always_comb begin
    o_next_pc = i_pc + NB_DATA'(4);
    if (i_branch_taken)  o_next_pc = i_branch_addr;
    else if (i_jump)     o_next_pc = i_jump_addr;
  end

  // A real fetch is latched only in RUN, stepped, not flushed and not stalled.
  logic latch_fetch, halt_fetch;

  assign latch_fetch = (state == RUN) && i_enable && !i_flush && !i_stall;
  assign halt_fetch  = latch_fetch && ((fetch_word == HALT_WORD) || misaligned);

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_loading   = 1'b0;
    o_halt      = 1'b0;
    o_pc_enable = 1'b0;
    case (state)
      IDLE: begin
        if (i_load_start) state_nxt = LOAD;
      end
      LOAD: begin
        o_loading = 1'b1;
        // Done on the HALT word or once the last memory slot is filled.
        if (word_wr && ((asm_word == HALT_WORD) || (wr_ptr == '1))) state_nxt = RUN;
      end
      RUN: begin
        o_pc_enable = i_enable && !i_stall;
        if (halt_fetch) state_nxt = HALTED;
      end
      HALTED: begin
        o_halt = 1'b1;
        if (i_load_start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ----------------------------------------------------------------- IF/ID
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_instr    <= '0;
      o_pc_plus4 <= '0;
      o_valid    <= 1'b0;
    end else if ((state == RUN) && i_enable) begin
      if (i_flush) begin
        o_instr    <= '0;
        o_pc_plus4 <= '0;
        o_valid    <= 1'b0;
      end else if (!i_stall) begin
        o_instr    <= fetch_word;
        o_pc_plus4 <= i_pc + NB_DATA'(4);
        o_valid    <= !misaligned;
      end
    end
  end

endmodule
